regfile_wb_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order pipeline writeback stage and NUM_MC multi-cycle units (mult/div, late load return).
- The pipeline has priority by default.
- A starvation counter forces a multi-cycle grant, and stalls the pipeline, after STARVE_LIMIT consecutive denied cycles.
- Multi-cycle units are served round-robin among themselves.
- Outputs are registered and drive reg_write/write_reg/write_data of the register file, which writes on negedge.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs NUM_MC multi-cycle units.
// Optional macro WB_ARB_PERF_EN adds a saturating pipeline-stall counter output.
module regfile_wb_arbiter #(
    parameter int NUM_MC       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [4:0]            pipe_reg,
    input  logic [31:0]           pipe_data,
    input  logic [NUM_MC-1:0]     mc_valid,
    output logic [NUM_MC-1:0]     mc_ready,
    input  logic [5*NUM_MC-1:0]   mc_reg,
    input  logic [32*NUM_MC-1:0]  mc_data,
    output logic                  reg_write,
    output logic [4:0]            write_reg,
    output logic [31:0]           write_data,
    output logic [3:0]            wb_src
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]           pipe_stall_cnt
`endif
);

    localparam int PW = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    // Handshake: a transfer happens on a posedge where valid && ready; a
    // requester holds valid, reg and data stable until it sees ready.
    logic [7:0]        starve_cnt;
    logic [PW-1:0]     rr_ptr;
    logic              force_mc;
    logic              mc_en;
    logic              pipe_xfer;
    logic              mc_xfer;
    logic              found;
    logic [PW-1:0]     grant_idx;
    logic [NUM_MC-1:0] grant;
    logic [4:0]        sel_reg;
    logic [31:0]       sel_data;

    assign force_mc   = (|mc_valid) && (starve_cnt >= 8'(STARVE_LIMIT));
    assign pipe_ready = !rst && !force_mc;
    assign mc_en      = !rst && (!pipe_valid || force_mc);
    assign pipe_xfer  = pipe_valid && pipe_ready;
    assign mc_xfer    = |grant;
    assign mc_ready   = grant;

    // Round-robin: first pass covers units at or above rr_ptr, second pass wraps.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            if (!found && mc_valid[i] && (PW'(i) >= rr_ptr)) begin
                found     = 1'b1;
                grant_idx = PW'(i);
            end
        end
        for (int i = 0; i < NUM_MC; i++) begin
            if (!found && mc_valid[i]) begin
                found     = 1'b1;
                grant_idx = PW'(i);
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            if (grant_idx == PW'(i)) begin
                grant[i] = found && mc_en;
                sel_reg  = mc_reg[5*i +: 5];
                sel_data = mc_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            wb_src     <= '0;
            starve_cnt <= '0;
            rr_ptr     <= '0;
        end else begin
            // r0 transfers complete normally but never raise the write enable.
            if (pipe_xfer) begin
                reg_write  <= (pipe_reg != 5'd0);
                write_reg  <= pipe_reg;
                write_data <= pipe_data;
                wb_src     <= 4'd0;
            end else if (mc_xfer) begin
                reg_write  <= (sel_reg != 5'd0);
                write_reg  <= sel_reg;
                write_data <= sel_data;
                wb_src     <= 4'(grant_idx) + 4'd1;
            end else begin
                reg_write  <= 1'b0;
                wb_src     <= 4'd0;
            end

            if (mc_xfer) begin
                rr_ptr <= (grant_idx == PW'(NUM_MC - 1)) ? '0 : grant_idx + PW'(1);
            end

            if (mc_xfer || !(|mc_valid)) begin
                starve_cnt <= '0;
            end else if (starve_cnt < 8'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_stall_cnt <= '0;
        end else if (pipe_valid && !pipe_ready && (pipe_stall_cnt != 32'hFFFF_FFFF)) begin
            pipe_stall_cnt <= pipe_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against
// a cycle-level behavioural model and a shadow register file.
module tb_regfile_wb_arbiter;
  localparam int N = 2;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           pipe_valid;
  logic           pipe_ready;
  logic [4:0]     pipe_reg;
  logic [31:0]    pipe_data;
  logic [N-1:0]   mc_valid;
  logic [N-1:0]   mc_ready;
  logic [5*N-1:0] mc_reg;
  logic [32*N-1:0] mc_data;
  logic           reg_write;
  logic [4:0]     write_reg;
  logic [31:0]    write_data;
  logic [3:0]     wb_src;
`ifdef WB_ARB_PERF_EN
  logic [31:0]    pipe_stall_cnt;
`endif

  regfile_wb_arbiter #(.NUM_MC(N), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
    .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_reg(mc_reg), .mc_data(mc_data),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .wb_src(wb_src)
`ifdef WB_ARB_PERF_EN
    , .pipe_stall_cnt(pipe_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model state
  int          m_starve;
  int          m_ptr;
  int          m_stall;
  logic        e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [3:0]  e_src;
  logic [31:0] rf   [32];
  logic [31:0] m_rf [32];
  logic        acc_pipe;
  logic [N-1:0] acc_mc;
  int          g;
  logic        m_force;
  logic [N-1:0] e_mc_ready;

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf[r] = '0;
      m_rf[r] = '0;
    end
  end

  // compare process: registered outputs reflect the previous cycle's decision,
  // readies are checked against the model's decision for the current inputs
  always @(negedge clk) begin
    if (rst) begin
      m_starve = 0; m_ptr = 0; m_stall = 0;
      e_we = 1'b0; e_reg = '0; e_data = '0; e_src = '0;
      acc_pipe = 1'b0; acc_mc = '0;
      chk("rst_reg_write", reg_write, 0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_wb_src", wb_src, 0);
      chk("rst_pipe_ready", pipe_ready, 0);
      chk("rst_mc_ready", mc_ready, 0);
    end else begin
      if (reg_write) rf[write_reg] = write_data;
      chk("reg_write", reg_write, e_we);
      chk("write_reg", write_reg, e_reg);
      chk("write_data", write_data, e_data);
      chk("wb_src", wb_src, e_src);
`ifdef WB_ARB_PERF_EN
      chk("pipe_stall_cnt", pipe_stall_cnt, m_stall);
`endif
      m_force = (mc_valid != 0) && (m_starve >= L);
      g = -1;
      if (!pipe_valid || m_force) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && mc_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      e_mc_ready = (g >= 0) ? N'(1 << g) : '0;
      chk("pipe_ready", pipe_ready, !m_force);
      chk("mc_ready", mc_ready, e_mc_ready);
      acc_pipe = pipe_valid && pipe_ready;
      acc_mc = mc_valid & mc_ready;
      if (pipe_valid && m_force) m_stall++;
      if (pipe_valid && !m_force) begin
        e_we = (pipe_reg != 0); e_reg = pipe_reg; e_data = pipe_data; e_src = 0;
        if (pipe_reg != 0) m_rf[pipe_reg] = pipe_data;
      end else if (g >= 0) begin
        e_reg = mc_reg[5*g +: 5]; e_data = mc_data[32*g +: 32];
        e_we = (e_reg != 0); e_src = 4'(g + 1);
        if (e_reg != 0) m_rf[e_reg] = e_data;
        m_ptr = (g + 1) % N;
      end else begin
        e_we = 1'b0; e_src = 0;
      end
      if (g >= 0 || mc_valid == 0) m_starve = 0;
      else if (m_starve < L) m_starve++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  int pipe_pct;
  int mc_pct;

  task automatic rand_cycle();
    tick();
    if (!pipe_valid || acc_pipe) begin
      pipe_valid = ($urandom_range(0, 99) < pipe_pct);
      pipe_reg = 5'($urandom_range(0, 31));
      pipe_data = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      if (!mc_valid[i] || acc_mc[i]) begin
        mc_valid[i] = ($urandom_range(0, 99) < mc_pct);
        mc_reg[5*i +: 5] = 5'($urandom_range(1, 31));
        mc_data[32*i +: 32] = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
    mc_valid = '0; mc_reg = '0; mc_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // pipe only
    pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEADBEEF;
    sample();
    chk("po_pipe_ready", pipe_ready, 1);
    tick();
    pipe_valid = 1'b0;
    sample();
    chk("po_reg_write", reg_write, 1);
    chk("po_write_reg", write_reg, 5);
    chk("po_write_data", write_data, 32'hDEADBEEF);
    chk("po_wb_src", wb_src, 0);
    chk("po_rf5", rf[5], 32'hDEADBEEF);

    // starvation: pipe wins four cycles, unit0 forced on the fifth
    tick();
    mc_valid = 2'b01; mc_reg[4:0] = 5'd7; mc_data[31:0] = 32'h11;
    pipe_valid = 1'b1; pipe_reg = 5'd10; pipe_data = 32'hA0;
    for (int c = 1; c <= 5; c++) begin
      sample();
      chk("st_pipe_ready", pipe_ready, (c < 5) ? 1 : 0);
      chk("st_mc_ready", mc_ready, (c == 5) ? 1 : 0);
      tick();
      if (c < 5) begin
        pipe_reg = 5'(10 + c);
        pipe_data = 32'hA0 + c;
      end else begin
        mc_valid = '0;
      end
    end
    sample();
    chk("st_write_reg", write_reg, 7);
    chk("st_write_data", write_data, 32'h11);
    chk("st_wb_src", wb_src, 1);
    chk("st_pipe_ready6", pipe_ready, 1);
`ifdef WB_ARB_PERF_EN
    chk("st_stall_cnt", pipe_stall_cnt, 1);
`endif
    tick();
    pipe_valid = 1'b0;

    // r0 destination
    pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hFFFF;
    sample();
    chk("r0_pipe_ready", pipe_ready, 1);
    tick();
    pipe_valid = 1'b0;
    sample();
    chk("r0_reg_write", reg_write, 0);
    chk("r0_write_data", write_data, 32'hFFFF);
    chk("r0_rf0", rf[0], 0);

    // reset mid-operation with a write pending
    tick();
    pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h33;
    tick();
    pipe_valid = 1'b0;
    chk("mr_reg_write_pre", reg_write, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_reg_write", reg_write, 0);
    chk("mr_pipe_ready", pipe_ready, 0);
    chk("mr_mc_ready", mc_ready, 0);
    tick();
    tick();
    rst = 1'b0;

    // round-robin with pipe idle, both units held valid
    mc_valid = 2'b11;
    mc_reg = {5'd9, 5'd8};
    mc_data = {32'h900, 32'h800};
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("rr_mc_ready", mc_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (c > 0) chk("rr_wb_src", wb_src, ((c - 1) % 2) + 1);
      tick();
      mc_data[32*(c % 2) +: 32] = 32'h1000 + c;
    end
    mc_valid = '0;
    tick();

    // random traffic
    pipe_pct = 90; mc_pct = 40;
    repeat (600) rand_cycle();
    pipe_pct = 50; mc_pct = 30;
    repeat (600) rand_cycle();
    pipe_pct = 10; mc_pct = 50;
    repeat (600) rand_cycle();
    pipe_pct = 0; mc_pct = 0;
    repeat (20) rand_cycle();
    repeat (3) tick();

    for (int r = 0; r < 32; r++) chk("regfile", rf[r], m_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
